// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: single-outstanding fetch requester with a one-entry
// hand-off buffer, redirect/drop handling and a speculation-depth throttle.
module ysyx_ifu #(
    parameter int                 BIT_W    = 32,
    parameter logic [BIT_W-1:0]   RESET_PC = 32'h3000_0000,
    parameter int                 SPEC_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    output logic [BIT_W-1:0] araddr_o,
    output logic             arvalid_o,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic             rvalid,
    output logic [31:0]      inst_o,
    output logic [BIT_W-1:0] pc_o,
    output logic             speculation_o,
    output logic             valid_o,
    input  logic             next_ready,
    input  logic             redirect_valid,
    input  logic [BIT_W-1:0] redirect_pc,
    input  logic             resolve
);

    localparam int                CNT_W      = $clog2(SPEC_MAX + 1);
    localparam logic [CNT_W-1:0]  SPEC_MAX_C = CNT_W'(SPEC_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [BIT_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;
    logic             drop_q, drop_d;
    logic [31:0]      inst_q, inst_d;
    logic [BIT_W-1:0] pc_out_q, pc_out_d;
    logic             spec_q, spec_d;
    logic             handoff;
    logic             inc, dec;

    function automatic logic is_ctrl_flow(input logic [31:0] inst);
        return (inst[6:0] == 7'b1101111) || (inst[6:0] == 7'b1100111) ||
               (inst[6:0] == 7'b1100011);
    endfunction

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        spec_cnt_d = spec_cnt_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        pc_out_d   = pc_out_q;
        spec_d     = spec_q;
        arvalid_o  = 1'b0;
        valid_o    = 1'b0;
        handoff    = 1'b0;

        case (state_q)
            IDLE: begin
                arvalid_o = (spec_cnt_q < SPEC_MAX_C);
                if (arvalid_o && arready) begin
                    state_d = WAIT_R;
                    drop_d  = redirect_valid;
                end
            end
            WAIT_R: begin
                if (rvalid) begin
                    if (drop_q || redirect_valid) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        inst_d   = rdata;
                        pc_out_d = pc_q;
                        spec_d   = (spec_cnt_q != '0);
                        pc_d     = pc_q + BIT_W'(4);
                        state_d  = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                valid_o = !redirect_valid;
                if (redirect_valid) begin
                    state_d = IDLE;
                end else if (next_ready) begin
                    handoff = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A resolve with nothing outstanding refers to no instruction and is dropped.
        inc = handoff && is_ctrl_flow(inst_q);
        dec = resolve && (spec_cnt_q != '0);
        if (inc && !dec) begin
            spec_cnt_d = spec_cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            spec_cnt_d = spec_cnt_q - CNT_W'(1);
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc;
            spec_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            spec_cnt_q <= '0;
            drop_q     <= 1'b0;
            inst_q     <= '0;
            pc_out_q   <= '0;
            spec_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            spec_cnt_q <= spec_cnt_d;
            drop_q     <= drop_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
            spec_q     <= spec_d;
        end
    end

    assign araddr_o      = pc_q;
    assign inst_o        = inst_q;
    assign pc_o          = pc_out_q;
    assign speculation_o = spec_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: the bench plays memory and decode, and a
// transaction-level model tracks the expected fetch pc and speculation depth.
module tb_ysyx_ifu;

    localparam int          BIT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam int          SPEC_MAX = 7;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0000_006f;
    localparam logic [31:0] JALR = 32'h0000_8067;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] ADD  = 32'h0000_0033;

    logic             clk;
    logic             rst;
    logic [BIT_W-1:0] araddr_o;
    logic             arvalid_o;
    logic             arready;
    logic [31:0]      rdata;
    logic             rvalid;
    logic [31:0]      inst_o;
    logic [BIT_W-1:0] pc_o;
    logic             speculation_o;
    logic             valid_o;
    logic             next_ready;
    logic             redirect_valid;
    logic [BIT_W-1:0] redirect_pc;
    logic             resolve;

    int          checks;
    int          errors;
    logic [31:0] m_pc;
    int          m_cnt;
    logic [31:0] last_word;

    ysyx_ifu #(.BIT_W(BIT_W), .RESET_PC(RESET_PC), .SPEC_MAX(SPEC_MAX)) dut (
        .clk(clk), .rst(rst), .araddr_o(araddr_o), .arvalid_o(arvalid_o),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .inst_o(inst_o),
        .pc_o(pc_o), .speculation_o(speculation_o), .valid_o(valid_o),
        .next_ready(next_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .resolve(resolve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_cf(input logic [31:0] w);
        return (w[6:0] == 7'h6f) || (w[6:0] == 7'h67) || (w[6:0] == 7'h63);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; next_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; resolve = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_pc = RESET_PC; m_cnt = 0;
        #1;
    endtask

    task automatic issue(input int rdly);
        checks++; if (arvalid_o !== 1'b1) begin errors++; $display("FAIL issue_arvalid got %0b exp 1", arvalid_o); end
        checks++; if (araddr_o !== m_pc) begin errors++; $display("FAIL issue_araddr got %h exp %h", araddr_o, m_pc); end
        for (int i = 0; i < rdly; i++) begin
            tick();
            checks++; if (arvalid_o !== 1'b1 || araddr_o !== m_pc) begin errors++; $display("FAIL issue_hold got %0b/%h exp 1/%h", arvalid_o, araddr_o, m_pc); end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++; if (arvalid_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL wait_outputs got arvalid %0b valid %0b exp 0/0", arvalid_o, valid_o); end
    endtask

    task automatic respond(input logic [31:0] word, input int dly);
        logic exp_spec;
        for (int i = 0; i < dly; i++) begin
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL wait_valid got %0b exp 0", valid_o); end
        end
        exp_spec = (m_cnt != 0);
        rdata = word; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid got %0b exp 1", valid_o); end
        checks++; if (inst_o !== word) begin errors++; $display("FAIL hold_inst got %h exp %h", inst_o, word); end
        checks++; if (pc_o !== m_pc) begin errors++; $display("FAIL hold_pc got %h exp %h", pc_o, m_pc); end
        checks++; if (speculation_o !== exp_spec) begin errors++; $display("FAIL hold_spec got %0b exp %0b", speculation_o, exp_spec); end
        last_word = word;
        m_pc = m_pc + 32'd4;
    endtask

    task automatic handoff(input int hold);
        logic [31:0] held_pc;
        held_pc = m_pc - 32'd4;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++; if (valid_o !== 1'b1 || inst_o !== last_word || pc_o !== held_pc || arvalid_o !== 1'b0) begin
                errors++; $display("FAIL hold_stable got v%0b %h %h a%0b exp v1 %h %h a0", valid_o, inst_o, pc_o, arvalid_o, last_word, held_pc);
            end
        end
        next_ready = 1'b1;
        tick();
        next_ready = 1'b0;
        if (is_cf(last_word)) m_cnt++;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL post_handoff_valid got %0b exp 0", valid_o); end
        checks++; if (arvalid_o !== (m_cnt < SPEC_MAX)) begin errors++; $display("FAIL post_handoff_arvalid got %0b exp %0b", arvalid_o, m_cnt < SPEC_MAX); end
        checks++; if (araddr_o !== m_pc) begin errors++; $display("FAIL post_handoff_araddr got %h exp %h", araddr_o, m_pc); end
    endtask

    task automatic do_resolve();
        resolve = 1'b1;
        tick();
        resolve = 1'b0;
        if (m_cnt > 0) m_cnt--;
    endtask

    task automatic fetch(input logic [31:0] word);
        issue(0); respond(word, 0); handoff(0);
    endtask

    task automatic redirect_in_wait(input logic [31:0] addr, input bit same_cycle, input int dly);
        redirect_valid = 1'b1; redirect_pc = addr; rvalid = same_cycle; rdata = 32'hdead_beef;
        tick();
        redirect_valid = 1'b0; rvalid = 1'b0;
        m_pc = addr; m_cnt = 0;
        if (!same_cycle) begin
            checks++; if (valid_o !== 1'b0 || arvalid_o !== 1'b0) begin errors++; $display("FAIL drop_wait got v%0b a%0b exp 0/0", valid_o, arvalid_o); end
            for (int i = 0; i < dly; i++) tick();
            rvalid = 1'b1;
            tick();
            rvalid = 1'b0;
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drop_valid got %0b exp 0", valid_o); end
        checks++; if (arvalid_o !== 1'b1 || araddr_o !== addr) begin errors++; $display("FAIL drop_refetch got a%0b %h exp a1 %h", arvalid_o, araddr_o, addr); end
        tick();
        checks++; if (valid_o !== 1'b0 || araddr_o !== addr) begin errors++; $display("FAIL drop_idle got v%0b %h exp v0 %h", valid_o, araddr_o, addr); end
    endtask

    task automatic test_reset();
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; next_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; resolve = 1'b0;
        tick(); tick();
        checks++; if (valid_o !== 1'b0 || speculation_o !== 1'b0) begin errors++; $display("FAIL reset_flags got v%0b s%0b exp 0/0", valid_o, speculation_o); end
        checks++; if (inst_o !== 32'd0 || pc_o !== 32'd0) begin errors++; $display("FAIL reset_regs got %h %h exp 0 0", inst_o, pc_o); end
        rst = 1'b0;
        m_pc = RESET_PC; m_cnt = 0;
        #1;
        checks++; if (arvalid_o !== 1'b1 || araddr_o !== RESET_PC) begin errors++; $display("FAIL reset_first_fetch got a%0b %h exp a1 %h", arvalid_o, araddr_o, RESET_PC); end
    endtask

    task automatic test_sequential();
        reset_dut();
        for (int i = 0; i < 3; i++) fetch(NOP);
        checks++; if (m_pc !== 32'h3000_000c || araddr_o !== 32'h3000_000c) begin errors++; $display("FAIL seq_next_pc got %h exp 3000000c", araddr_o); end
    endtask

    task automatic test_jal_spec();
        reset_dut();
        fetch(JAL);
        fetch(NOP);
        do_resolve();
        fetch(NOP);
        checks++; if (speculation_o !== 1'b0) begin errors++; $display("FAIL jal_resolved_spec got %0b exp 0", speculation_o); end
    endtask

    task automatic test_redirect_wait();
        reset_dut();
        fetch(JAL);
        issue(0);
        redirect_in_wait(32'h8000_0000, 1'b0, 0);
        fetch(NOP);
        issue(1);
        redirect_in_wait(32'h8000_0100, 1'b1, 0);
        fetch(ADD);
    endtask

    task automatic test_hold_redirect();
        reset_dut();
        issue(0); respond(BEQ, 1); handoff(5);
        issue(0); respond(JALR, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (inst_o !== JALR || pc_o !== m_pc - 32'd4 || arvalid_o !== 1'b0 || valid_o !== 1'b1) begin
                errors++; $display("FAIL hold5 got %h %h a%0b v%0b", inst_o, pc_o, arvalid_o, valid_o);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h4000_0000; next_ready = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL hold_redirect_valid got %0b exp 0", valid_o); end
        tick();
        redirect_valid = 1'b0; next_ready = 1'b0;
        m_pc = 32'h4000_0000; m_cnt = 0;
        checks++; if (valid_o !== 1'b0 || arvalid_o !== 1'b1 || araddr_o !== m_pc) begin errors++; $display("FAIL hold_redirect_idle got v%0b a%0b %h", valid_o, arvalid_o, araddr_o); end
        fetch(NOP);
        checks++; if (speculation_o !== 1'b0) begin errors++; $display("FAIL hold_redirect_spec got %0b exp 0", speculation_o); end
    endtask

    task automatic test_idle_redirect();
        reset_dut();
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
        tick();
        redirect_valid = 1'b0; m_pc = 32'hffff_fffc;
        checks++; if (arvalid_o !== 1'b1 || araddr_o !== m_pc) begin errors++; $display("FAIL idle_redirect got a%0b %h exp a1 %h", arvalid_o, araddr_o, m_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; arready = 1'b1;
        tick();
        redirect_valid = 1'b0; arready = 1'b0; m_pc = 32'h0000_1000;
        checks++; if (arvalid_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL idle_redirect_hs got a%0b v%0b exp 0/0", arvalid_o, valid_o); end
        rvalid = 1'b1; rdata = ADD;
        tick();
        rvalid = 1'b0;
        checks++; if (valid_o !== 1'b0 || arvalid_o !== 1'b1 || araddr_o !== m_pc) begin errors++; $display("FAIL idle_redirect_drop got v%0b a%0b %h", valid_o, arvalid_o, araddr_o); end
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
        tick();
        redirect_valid = 1'b0; m_pc = 32'hffff_fffc;
        fetch(NOP);
        checks++; if (araddr_o !== 32'd0) begin errors++; $display("FAIL pc_wrap got %h exp 0", araddr_o); end
    endtask

    task automatic test_spec_limit();
        reset_dut();
        for (int i = 0; i < SPEC_MAX; i++) fetch(BEQ);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL spec_limit_stall got %0b exp 0", arvalid_o); end
        end
        do_resolve();
        checks++; if (arvalid_o !== 1'b1 || araddr_o !== m_pc) begin errors++; $display("FAIL spec_limit_release got a%0b %h exp a1 %h", arvalid_o, araddr_o, m_pc); end
        fetch(NOP);
    endtask

    task automatic test_reset_mid();
        reset_dut();
        fetch(NOP);
        issue(0);
        rst = 1'b1;
        tick();
        rst = 1'b0; m_pc = RESET_PC; m_cnt = 0;
        #1;
        checks++; if (arvalid_o !== 1'b1 || araddr_o !== RESET_PC || valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid got a%0b %h v%0b", arvalid_o, araddr_o, valid_o); end
        rvalid = 1'b1; rdata = JAL;
        tick();
        rvalid = 1'b0;
        checks++; if (valid_o !== 1'b0 || arvalid_o !== 1'b1 || araddr_o !== RESET_PC) begin errors++; $display("FAIL stray_rvalid got v%0b a%0b %h", valid_o, arvalid_o, araddr_o); end
        fetch(NOP);
    endtask

    task automatic test_random();
        logic [31:0] pool [5];
        logic [31:0] word;
        pool = '{NOP, JAL, JALR, BEQ, ADD};
        reset_dut();
        for (int n = 0; n < 200; n++) begin
            if (m_cnt == SPEC_MAX) begin
                checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL rnd_stall got %0b exp 0", arvalid_o); end
                do_resolve();
            end else if (m_cnt > 0 && $urandom_range(3) == 0) begin
                do_resolve();
            end
            word = pool[$urandom_range(4)];
            issue(int'($urandom_range(2)));
            if ($urandom_range(9) == 0) begin
                redirect_in_wait($urandom() & 32'hffff_fffc, 1'($urandom_range(1)), int'($urandom_range(2)));
            end else begin
                respond(word, int'($urandom_range(3)));
                handoff(int'($urandom_range(2)));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_jal_spec();
        test_redirect_wait();
        test_hold_redirect();
        test_idle_redirect();
        test_spec_limit();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
